itof_pipe: RTL and testbench

- Pipelined int32 -> IEEE-754 single-precision converter; the reverse path of the existing float-to-int unit in the FPU.
- Accepts one integer per cycle over a valid/ready handshake and returns the correctly rounded float 3 cycles later.
- Rounding is round-to-nearest, ties-to-even.
- Sits beside the other FPU units and is driven by the core's execute-stage dispatch.

---
 rtl/itof_pipe_if.sv | 21 ++
 rtl/itof_pipe.sv | 124 ++++++++++++
 tb/tb_itof_pipe.sv | 297 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/itof_pipe_if.sv
// Valid/ready operand and result channels of the int32 -> float converter.
interface itof_pipe_if;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic        out_inexact;
  logic        out_zero;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_inexact, out_zero
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_inexact, out_zero
  );
endinterface

// File: rtl/itof_pipe.sv
// Three-stage int32/uint32 -> IEEE-754 single converter, round-to-nearest-even.
// S1 sign/magnitude, S2 normalise, S3 round and pack; one global stall enable.
module itof_pipe #(
  parameter bit SIGNED = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  itof_pipe_if.slave  bus
);

  logic        en;

  logic        s1_valid_q, s1_valid_d;
  logic        s1_sign_q, s1_sign_d;
  logic [31:0] s1_mag_q, s1_mag_d;

  logic        s2_valid_q, s2_valid_d;
  logic        s2_sign_q, s2_sign_d;
  logic [4:0]  s2_p_q, s2_p_d;
  logic [31:0] s2_norm_q, s2_norm_d;

  logic        s3_valid_q, s3_valid_d;
  logic [31:0] s3_data_q, s3_data_d;
  logic        s3_inexact_q, s3_inexact_d;
  logic        s3_zero_q, s3_zero_d;

  logic [4:0]  msb;
  logic [23:0] kept;
  logic        guard;
  logic        sticky;
  logic        round_up;
  logic [24:0] sum;
  logic [7:0]  exp_field;
  logic [22:0] frac;
  logic        is_zero;

  assign en            = ~s3_valid_q | bus.out_ready;
  assign bus.in_ready  = en;
  assign bus.out_valid   = s3_valid_q;
  assign bus.out_data    = s3_data_q;
  assign bus.out_inexact = s3_inexact_q;
  assign bus.out_zero    = s3_zero_q;

  // S1: 0x80000000 negates to itself, which reads correctly as 2^31 unsigned.
  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_sign_d  = s1_sign_q;
    s1_mag_d   = s1_mag_q;
    if (en) begin
      s1_valid_d = bus.in_valid;
      s1_sign_d  = SIGNED & bus.in_data[31];
      s1_mag_d   = s1_sign_d ? (~bus.in_data + 32'd1) : bus.in_data;
    end
  end

  always_comb begin
    msb = 5'd0;
    for (int i = 0; i < 32; i++) begin
      if (s1_mag_q[i]) msb = i[4:0];
    end
    s2_valid_d = s2_valid_q;
    s2_sign_d  = s2_sign_q;
    s2_p_d     = s2_p_q;
    s2_norm_d  = s2_norm_q;
    if (en) begin
      s2_valid_d = s1_valid_q;
      s2_sign_d  = s1_sign_q;
      s2_p_d     = msb;
      s2_norm_d  = s1_mag_q << (5'd31 - msb);
    end
  end

  // S3: a zero operand normalises to all-zero, so sum==0 identifies it.
  always_comb begin
    kept      = s2_norm_q[31:8];
    guard     = s2_norm_q[7];
    sticky    = |s2_norm_q[6:0];
    round_up  = guard & (sticky | kept[0]);
    sum       = {1'b0, kept} + {24'd0, round_up};
    is_zero   = ~(sum[24] | sum[23]);
    exp_field = 8'd127 + {3'd0, s2_p_q} + {7'd0, sum[24]};
    frac      = sum[24] ? 23'd0 : sum[22:0];

    s3_valid_d   = s3_valid_q;
    s3_data_d    = s3_data_q;
    s3_inexact_d = s3_inexact_q;
    s3_zero_d    = s3_zero_q;
    if (en) begin
      s3_valid_d   = s2_valid_q;
      s3_data_d    = is_zero ? 32'd0 : {s2_sign_q, exp_field, frac};
      s3_inexact_d = ~is_zero & (guard | sticky);
      s3_zero_d    = is_zero;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q   <= 1'b0;
      s1_sign_q    <= 1'b0;
      s1_mag_q     <= 32'd0;
      s2_valid_q   <= 1'b0;
      s2_sign_q    <= 1'b0;
      s2_p_q       <= 5'd0;
      s2_norm_q    <= 32'd0;
      s3_valid_q   <= 1'b0;
      s3_data_q    <= 32'd0;
      s3_inexact_q <= 1'b0;
      s3_zero_q    <= 1'b0;
    end else begin
      s1_valid_q   <= s1_valid_d;
      s1_sign_q    <= s1_sign_d;
      s1_mag_q     <= s1_mag_d;
      s2_valid_q   <= s2_valid_d;
      s2_sign_q    <= s2_sign_d;
      s2_p_q       <= s2_p_d;
      s2_norm_q    <= s2_norm_d;
      s3_valid_q   <= s3_valid_d;
      s3_data_q    <= s3_data_d;
      s3_inexact_q <= s3_inexact_d;
      s3_zero_q    <= s3_zero_d;
    end
  end

endmodule

// File: tb/tb_itof_pipe.sv
// Bench for itof_pipe: a signed and an unsigned instance share one stimulus
// stream; each has its own expected-result queue checked at the output.
module tb_itof_pipe;

  typedef struct {
    logic [31:0] data;
    logic        inex;
    logic        zero;
    int          cyc;
  } exp_t;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic [31:0] in_data;
  logic        out_ready;

  int   checks;
  int   errors;
  int   cyc;
  bit   lat_chk;
  bit   bp_mode;
  int   bp_cnt;
  exp_t q_s[$];
  exp_t q_u[$];
  logic        stall_s, stall_u;
  logic [31:0] pdata_s, pdata_u;

  itof_pipe_if bus_s ();
  itof_pipe_if bus_u ();

  assign bus_s.in_valid  = in_valid;
  assign bus_s.in_data   = in_data;
  assign bus_s.out_ready = out_ready;
  assign bus_u.in_valid  = in_valid;
  assign bus_u.in_data   = in_data;
  assign bus_u.out_ready = out_ready;

  itof_pipe #(.SIGNED(1'b1)) u_dut_s (.clk(clk), .rst(rst), .bus(bus_s));
  itof_pipe #(.SIGNED(1'b0)) u_dut_u (.clk(clk), .rst(rst), .bus(bus_u));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, expv);
    end
  endtask

  // Reference: shift right by (msb-23) and round on the remainder.
  function automatic logic [33:0] ref_itof(input logic [31:0] x, input bit sgn);
    logic            s;
    longint unsigned mag, kept, rem, half;
    int              p, sh;
    logic [7:0]      e;
    logic            inex;
    s = sgn && x[31];
    mag = s ? (64'h1_0000_0000 - {32'd0, x}) : {32'd0, x};
    if (mag == 0) return {1'b1, 1'b0, 32'd0};
    p = 0;
    while ((mag >> (p + 1)) != 0) p++;
    inex = 1'b0;
    if (p <= 23) begin
      kept = mag << (23 - p);
    end else begin
      sh   = p - 23;
      kept = mag >> sh;
      rem  = mag & ((64'd1 << sh) - 1);
      half = 64'd1 << (sh - 1);
      inex = (rem != 0);
      if (rem > half || (rem == half && kept[0])) kept++;
    end
    e = 8'(127 + p);
    if (kept == (64'd1 << 24)) begin
      kept = kept >> 1;
      e++;
    end
    return {1'b0, inex, s, e, kept[22:0]};
  endfunction

  task automatic mon_check(input string nm, input logic ov, input logic irdy,
                           input logic [31:0] od, input logic oi, input logic oz,
                           input bit have, input exp_t e,
                           input logic prev_stall, input logic [31:0] prev_data);
    chk1({nm, "_in_ready"}, irdy, ~ov | out_ready);
    if (prev_stall) begin
      chk1({nm, "_stall_valid_hold"}, ov, 1'b1);
      chk({nm, "_stall_data_hold"}, od, prev_data);
    end
    if (ov && out_ready) begin
      chk1({nm, "_expected_result_present"}, have, 1'b1);
      if (have) begin
        chk({nm, "_data"}, od, e.data);
        chk1({nm, "_inexact"}, oi, e.inex);
        chk1({nm, "_zero"}, oz, e.zero);
        if (lat_chk) chk({nm, "_latency"}, 32'(cyc), 32'(e.cyc + 3));
      end
    end
  endtask

  always @(negedge clk) begin
    exp_t e_s, e_u;
    bit   h_s, h_u;
    if (rst) begin
      q_s.delete();
      q_u.delete();
      stall_s = 1'b0;
      stall_u = 1'b0;
    end else begin
      h_s = 1'b0;
      h_u = 1'b0;
      e_s = '{32'd0, 1'b0, 1'b0, 0};
      e_u = '{32'd0, 1'b0, 1'b0, 0};
      if (bus_s.out_valid && out_ready && q_s.size() > 0) begin
        e_s = q_s.pop_front();
        h_s = 1'b1;
      end
      if (bus_u.out_valid && out_ready && q_u.size() > 0) begin
        e_u = q_u.pop_front();
        h_u = 1'b1;
      end
      mon_check("s", bus_s.out_valid, bus_s.in_ready, bus_s.out_data, bus_s.out_inexact,
                bus_s.out_zero, h_s, e_s, stall_s, pdata_s);
      mon_check("u", bus_u.out_valid, bus_u.in_ready, bus_u.out_data, bus_u.out_inexact,
                bus_u.out_zero, h_u, e_u, stall_u, pdata_u);
      stall_s = bus_s.out_valid & ~out_ready;
      stall_u = bus_u.out_valid & ~out_ready;
      pdata_s = bus_s.out_data;
      pdata_u = bus_u.out_data;
    end
  end

  always @(posedge clk) begin
    #1;
    if (bp_mode) begin
      bp_cnt++;
      out_ready = (bp_cnt >= 3 && bp_cnt < 8) ? 1'b0 : 1'($urandom_range(0, 1));
    end
  end

  // Called just after a rising edge; returns just after the accepting edge.
  task automatic send_k(input logic [31:0] v, input logic [31:0] ds, input logic is_,
                        input logic [31:0] du, input logic iu);
    int   n;
    logic acc;
    n = 0;
    in_valid = 1'b1;
    in_data  = v;
    forever begin
      @(negedge clk);
      acc = bus_s.in_ready;
      if (acc) begin
        q_s.push_back('{ds, is_, (v == 32'd0), cyc});
        q_u.push_back('{du, iu, (v == 32'd0), cyc});
      end
      @(posedge clk);
      #1;
      if (acc) break;
      n++;
      if (n > 50) begin
        chk1("send_timeout", acc, 1'b1);
        break;
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic send_m(input logic [31:0] v);
    logic [33:0] rs, ru;
    rs = ref_itof(v, 1'b1);
    ru = ref_itof(v, 1'b0);
    send_k(v, rs[31:0], rs[32], ru[31:0], ru[32]);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((q_s.size() != 0 || q_u.size() != 0) && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("drain_s_queue_empty", 32'(q_s.size()), 32'd0);
    chk("drain_u_queue_empty", 32'(q_u.size()), 32'd0);
  endtask

  initial begin
    checks    = 0;
    errors    = 0;
    cyc       = 0;
    lat_chk   = 1'b1;
    bp_mode   = 1'b0;
    bp_cnt    = 0;
    stall_s   = 1'b0;
    stall_u   = 1'b0;
    pdata_s   = 32'd0;
    pdata_u   = 32'd0;
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = 32'd0;
    out_ready = 1'b1;

    repeat (2) @(posedge clk);
    #1;
    chk1("reset_out_valid", bus_s.out_valid, 1'b0);
    chk("reset_out_data", bus_s.out_data, 32'd0);
    chk1("reset_out_inexact", bus_s.out_inexact, 1'b0);
    chk1("reset_out_zero", bus_s.out_zero, 1'b0);
    chk1("reset_u_out_valid", bus_u.out_valid, 1'b0);
    rst = 1'b0;
    @(negedge clk);
    chk1("post_reset_in_ready", bus_s.in_ready, 1'b1);
    @(posedge clk);
    #1;

    // Directed values at full rate.
    send_k(32'd1,          32'h3F800000, 1'b0, 32'h3F800000, 1'b0);
    send_k(32'hFFFFFFFF,   32'hBF800000, 1'b0, 32'h4F800000, 1'b1);
    send_k(32'd0,          32'h00000000, 1'b0, 32'h00000000, 1'b0);
    send_k(32'h80000000,   32'hCF000000, 1'b0, 32'h4F000000, 1'b0);
    send_k(32'd16777217,   32'h4B800000, 1'b1, 32'h4B800000, 1'b1);
    send_k(32'd16777219,   32'h4B800002, 1'b1, 32'h4B800002, 1'b1);
    send_k(32'd16777221,   32'h4B800002, 1'b1, 32'h4B800002, 1'b1);
    send_k(32'h7FFFFFFF,   32'h4F000000, 1'b1, 32'h4F000000, 1'b1);
    send_k(32'd16777216,   32'h4B800000, 1'b0, 32'h4B800000, 1'b0);
    send_m(32'hFFFFFF85);
    send_m(32'h00ABCDEF);
    drain();

    // Bubbles on alternate cycles.
    for (int i = 0; i < 6; i++) begin
      send_m($urandom);
      idle(1);
    end
    drain();

    // Backpressure with a random out_ready and a 5-cycle hold at 0.
    lat_chk = 1'b0;
    bp_cnt  = 0;
    bp_mode = 1'b1;
    for (int i = 0; i < 10; i++) send_m($urandom);
    drain();
    bp_mode   = 1'b0;
    out_ready = 1'b1;
    idle(2);
    lat_chk = 1'b1;

    // Reset with three operands in flight.
    out_ready = 1'b0;
    send_m(32'd5);
    send_m(32'hFFFFFFF0);
    send_m(32'd123456789);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk1("flush_s_out_valid", bus_s.out_valid, 1'b0);
    chk1("flush_u_out_valid", bus_u.out_valid, 1'b0);
    out_ready = 1'b1;
    idle(6);
    send_m(32'd1000);
    drain();
    idle(4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
